// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : sobel_pkg
//  Purpose   : Shared pixel type, scheduler state encoding and widths for the
//              sobel frame scheduler.
//  Revision  : 1.0  initial release
// ============================================================================
package sobel_pkg;

   localparam int PIX_W = 8;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/sobel_frame_sched_if.sv
`default_nettype none
// ============================================================================
//  Interface : sobel_frame_sched_if
//  Purpose   : Bundles source, filter-side and tagged-output signals of the
//              sobel frame scheduler. master = environment, slave = scheduler.
//  Revision  : 1.0  initial release
// ============================================================================
interface sobel_frame_sched_if #(
   parameter int NUM_CH = 2,
   parameter int W_BITS = 11,
   parameter int H_BITS = 11
);
   import sobel_pkg::*;

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [W_BITS-1:0]       cfg_width;
   logic [H_BITS-1:0]       cfg_height;
   logic [NUM_CH-1:0]       req_i;
   logic [PIX_W*NUM_CH-1:0] ch_data_i;
   logic [NUM_CH-1:0]       ch_valid_i;
   logic [NUM_CH-1:0]       ch_ready_o;
   pixel_t                  flt_data_o;
   logic                    flt_valid_o;
   pixel_t                  flt_data_i;
   logic                    flt_valid_i;
   pixel_t                  out_data;
   logic                    out_valid;
   logic [CH_W-1:0]         out_ch;
   logic                    out_sol;
   logic                    out_eol;
   logic                    out_eof;
   logic [NUM_CH-1:0]       done_o;
   logic                    err_o;
   logic                    busy;

   modport master (
      output cfg_width, cfg_height, req_i, ch_data_i, ch_valid_i,
             flt_data_i, flt_valid_i,
      input  ch_ready_o, flt_data_o, flt_valid_o, out_data, out_valid,
             out_ch, out_sol, out_eol, out_eof, done_o, err_o, busy
   );

   modport slave (
      input  cfg_width, cfg_height, req_i, ch_data_i, ch_valid_i,
             flt_data_i, flt_valid_i,
      output ch_ready_o, flt_data_o, flt_valid_o, out_data, out_valid,
             out_ch, out_sol, out_eol, out_eof, done_o, err_o, busy
   );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : rr_arbiter
//  Purpose   : Combinational round-robin pick: first requester at or above
//              ptr, wrapping. Returns one-hot grant and its index.
//  Revision  : 1.0  initial release
// ============================================================================
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic found;
   int   k;

   // Walk the channels starting at ptr; the first active request wins.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < N; i++) begin
         k = (int'(ptr) + i) % N;
         if (!found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = IW'(k);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sobel_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module    : sobel_frame_sched
//  Purpose   : Shares one sobel_filter among NUM_CH sources. Grants whole
//              frames round-robin, feeds the owner's pixels to the filter and
//              tags filter output with channel id and SOL/EOL/EOF.
//  Revision  : 1.0  initial release
// ============================================================================
module sobel_frame_sched #(
   parameter int NUM_CH    = 2,
   parameter int W_BITS    = 11,
   parameter int H_BITS    = 11,
   parameter int DRAIN_MAX = 64
) (
   input logic              clk,
   input logic              rst,
   sobel_frame_sched_if.slave bus
);
   import sobel_pkg::*;

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TW   = $clog2(DRAIN_MAX + 1);
   localparam int RC_W = W_BITS + H_BITS;

   sched_state_t      state, state_nxt;
   logic [CH_W-1:0]   owner, rr_ptr, arb_idx;
   logic [NUM_CH-1:0] owner_oh, arb_gnt;
   logic [W_BITS-1:0] frm_w, in_col, out_col;
   logic [H_BITS-1:0] frm_h, in_row, out_row;
   logic [TW-1:0]     drain_tmr;
   logic              out_complete;
   logic              in_acc, in_last, out_acc, out_eol_w, out_last;

   // Advance a col/row pair by one pixel: col wraps at w-1, row at h-1.
   function automatic logic [RC_W-1:0] rc_step(
      input logic [W_BITS-1:0] col,
      input logic [H_BITS-1:0] row,
      input logic [W_BITS-1:0] w,
      input logic [H_BITS-1:0] h
   );
      logic [W_BITS-1:0] c_n;
      logic [H_BITS-1:0] r_n;
      if (col == w - W_BITS'(1)) begin
         c_n = '0;
         r_n = (row == h - H_BITS'(1)) ? '0 : row + H_BITS'(1);
      end else begin
         c_n = col + W_BITS'(1);
         r_n = row;
      end
      return {r_n, c_n};
   endfunction

   rr_arbiter #(.N(NUM_CH)) u_arb (
      .req (bus.req_i),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   assign in_acc    = (state == FEED) && bus.ch_valid_i[owner];
   assign in_last   = in_acc && (in_col == frm_w - W_BITS'(1)) && (in_row == frm_h - H_BITS'(1));
   assign out_acc   = ((state == FEED) || (state == DRAIN)) && bus.flt_valid_i;
   assign out_eol_w = (out_col == frm_w - W_BITS'(1));
   assign out_last  = out_acc && out_eol_w && (out_row == frm_h - H_BITS'(1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode plus the state-derived handshake and status outputs.
   always_comb begin
      state_nxt      = state;
      bus.ch_ready_o = '0;
      bus.done_o     = '0;
      bus.err_o      = 1'b0;
      bus.busy       = (state != IDLE);
      case (state)
         IDLE:  if (|bus.req_i) state_nxt = GRANT;
         GRANT: state_nxt = FEED;
         FEED: begin
            bus.ch_ready_o = owner_oh;
            if (in_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (out_complete || out_last)             state_nxt = DONE;
            else if (drain_tmr == TW'(DRAIN_MAX))     state_nxt = ERR;
         end
         DONE: begin
            bus.done_o = owner_oh;
            state_nxt  = IDLE;
         end
         ERR: begin
            bus.err_o = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Owner capture on grant, frame geometry and round-robin pointer update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner    <= '0;
         owner_oh <= '0;
         rr_ptr   <= '0;
         frm_w    <= '0;
         frm_h    <= '0;
      end else begin
         if (state == IDLE && |bus.req_i) begin
            owner    <= arb_idx;
            owner_oh <= arb_gnt;
         end
         if (state == GRANT) begin
            frm_w  <= (bus.cfg_width  == '0) ? W_BITS'(1) : bus.cfg_width;
            frm_h  <= (bus.cfg_height == '0) ? H_BITS'(1) : bus.cfg_height;
            rr_ptr <= (owner == CH_W'(NUM_CH - 1)) ? '0 : owner + CH_W'(1);
         end
      end
   end

   // Input/output position counters, completion flag and drain timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_col       <= '0;
         in_row       <= '0;
         out_col      <= '0;
         out_row      <= '0;
         out_complete <= 1'b0;
         drain_tmr    <= '0;
      end else if (state == GRANT || state == DONE || state == ERR) begin
         in_col       <= '0;
         in_row       <= '0;
         out_col      <= '0;
         out_row      <= '0;
         out_complete <= 1'b0;
         drain_tmr    <= '0;
      end else begin
         if (in_acc)   {in_row, in_col}   <= rc_step(in_col, in_row, frm_w, frm_h);
         if (out_acc)  {out_row, out_col} <= rc_step(out_col, out_row, frm_w, frm_h);
         if (out_last) out_complete <= 1'b1;
         if (in_last || out_acc)
            drain_tmr <= '0;
         else if (state == DRAIN && drain_tmr != TW'(DRAIN_MAX))
            drain_tmr <= drain_tmr + TW'(1);
      end
   end

   // Register the accepted owner pixel toward the filter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.flt_valid_o <= 1'b0;
         bus.flt_data_o  <= '0;
      end else begin
         bus.flt_valid_o <= in_acc;
         if (in_acc) bus.flt_data_o <= bus.ch_data_i[PIX_W*int'(owner) +: PIX_W];
      end
   end

   // Register filter output with channel id and line/frame position tags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_ch    <= '0;
         bus.out_sol   <= 1'b0;
         bus.out_eol   <= 1'b0;
         bus.out_eof   <= 1'b0;
      end else begin
         bus.out_valid <= out_acc;
         bus.out_sol   <= out_acc && (out_col == '0);
         bus.out_eol   <= out_acc && out_eol_w;
         bus.out_eof   <= out_last;
         if (out_acc) begin
            bus.out_data <= bus.flt_data_i;
            bus.out_ch   <= owner;
         end
      end
   end

endmodule
`default_nettype wire
